// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: sequences one external full-adder cell over
// two WIDTH-bit operands, LSB first, and registers the WIDTH+1-bit result.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_c,
    input  logic             fa_sum,
    input  logic             fa_carry,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [CW-1:0]    r_cnt;
    logic             w_load;
    logic             w_last;
    logic [WIDTH-1:0] w_res_nxt;

    // A start is only honoured while the cell is not in use.
    assign w_load    = start && (r_state != S_RUN);
    assign w_last    = (r_cnt == CW'(WIDTH - 1));
    assign w_res_nxt = {fa_sum, r_res[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  w_next = start ? S_RUN : S_IDLE;
            S_RUN:   w_next = w_last ? S_DONE : S_RUN;
            S_DONE:  w_next = start ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_load) begin
            r_a_sh  <= op_a;
            r_b_sh  <= op_b;
            r_res   <= '0;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
            r_res   <= w_res_nxt;
            r_carry <= fa_carry;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_sum  <= w_res_nxt;
                r_cout <= fa_carry;
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        fa_a = 1'b0;
        fa_b = 1'b0;
        fa_c = 1'b0;
        unique case (r_state)
            S_RUN: begin
                busy = 1'b1;
                fa_a = r_a_sh[0];
                fa_b = r_b_sh[0];
                fa_c = r_carry;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: a WIDTH=8 and a WIDTH=4 instance,
// each wired to its own behavioural full-adder cell.
module tb_serial_add_ctrl;

    typedef struct {
        logic [8:0] val;
        int         at;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      st;
    logic [1:0][7:0] a;
    logic [1:0][7:0] b;
    logic [1:0]      ci;

    logic fa8_a, fa8_b, fa8_c, fa8_s, fa8_co;
    logic fa4_a, fa4_b, fa4_c, fa4_s, fa4_co;
    logic [7:0] sum8;
    logic [3:0] sum4;
    logic cout8, cout4;
    logic [1:0] busy_w, done_w, fa_any;
    logic [8:0] res_w [2];

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_k [2] = '{-1, -1};
    logic [8:0] held [2] = '{9'd0, 9'd0};
    exp_t q8 [$];
    exp_t q4 [$];

    always #5 clk = ~clk;

    assign fa8_s  = fa8_a ^ fa8_b ^ fa8_c;
    assign fa8_co = (fa8_a & fa8_b) | (fa8_a & fa8_c) | (fa8_b & fa8_c);
    assign fa4_s  = fa4_a ^ fa4_b ^ fa4_c;
    assign fa4_co = (fa4_a & fa4_b) | (fa4_a & fa4_c) | (fa4_b & fa4_c);

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(st[0]),
        .op_a(a[0]), .op_b(b[0]), .cin(ci[0]),
        .fa_a(fa8_a), .fa_b(fa8_b), .fa_c(fa8_c),
        .fa_sum(fa8_s), .fa_carry(fa8_co),
        .busy(busy_w[0]), .done(done_w[0]), .sum(sum8), .cout(cout8)
    );

    serial_add_ctrl #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(st[1]),
        .op_a(a[1][3:0]), .op_b(b[1][3:0]), .cin(ci[1]),
        .fa_a(fa4_a), .fa_b(fa4_b), .fa_c(fa4_c),
        .fa_sum(fa4_s), .fa_carry(fa4_co),
        .busy(busy_w[1]), .done(done_w[1]), .sum(sum4), .cout(cout4)
    );

    assign res_w[0]  = {cout8, sum8};
    assign res_w[1]  = {4'd0, cout4, sum4};
    assign fa_any[0] = fa8_a | fa8_b | fa8_c;
    assign fa_any[1] = fa4_a | fa4_b | fa4_c;

    function automatic int wid(input int d);
        return (d == 0) ? 8 : 4;
    endfunction

    // Reference: a request is taken when no add is in flight; the result
    // is the plain integer sum, due WIDTH edges after acceptance.
    always @(posedge clk) begin
        int   w, m, s;
        exp_t e;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            w = wid(d);
            if (rst_n && st[d] &&
                (last_k[d] < 0 || cyc >= last_k[d] + w + 1)) begin
                m = (1 << w) - 1;
                s = (int'(a[d]) & m) + (int'(b[d]) & m) + int'(ci[d]);
                last_k[d] = cyc;
                e.val = 9'(s);
                e.at  = cyc + w;
                if (d == 0) q8.push_back(e);
                else        q4.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        exp_t f;
        bit   have;
        bit   eb;
        for (int d = 0; d < 2; d++) begin
            eb = last_k[d] >= 0 && cyc >= last_k[d] && cyc < last_k[d] + wid(d);
            checks++;
            if (busy_w[d] !== eb) begin
                errors++;
                $display("FAIL busy[%0d] cyc=%0d got=%b exp=%b", d, cyc, busy_w[d], eb);
            end
            if (!eb) begin
                checks++;
                if (fa_any[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL fa_idle[%0d] cyc=%0d got=%b exp=0", d, cyc, fa_any[d]);
                end
            end
            have = (d == 0) ? (q8.size() > 0) : (q4.size() > 0);
            if (have) f = (d == 0) ? q8[0] : q4[0];
            if (done_w[d] === 1'b1) begin
                checks++;
                if (!have) begin
                    errors++;
                    $display("FAIL spurious_done[%0d] cyc=%0d got=1 exp=0", d, cyc);
                end else begin
                    if (d == 0) void'(q8.pop_front());
                    else        void'(q4.pop_front());
                    held[d] = f.val;
                    if (f.at != cyc) begin
                        errors++;
                        $display("FAIL done_time[%0d] got=%0d exp=%0d", d, cyc, f.at);
                    end
                end
            end else if (have && f.at <= cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_done[%0d] cyc=%0d got=0 exp=1", d, cyc);
                if (d == 0) void'(q8.pop_front());
                else        void'(q4.pop_front());
                held[d] = f.val;
            end
            checks++;
            if (res_w[d] !== held[d]) begin
                errors++;
                $display("FAIL result[%0d] cyc=%0d got=%h exp=%h", d, cyc, res_w[d], held[d]);
            end
        end
    end

    task automatic drain();
        int n = 0;
        while ((q8.size() > 0 || q4.size() > 0) && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got=%0d exp=0 pending", q8.size() + q4.size());
            q8.delete();
            q4.delete();
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        q8.delete();
        q4.delete();
        last_k = '{-1, -1};
        held   = '{9'd0, 9'd0};
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic run_op(input int d, input logic [7:0] x, input logic [7:0] y,
                          input logic c, input bit junk);
        @(posedge clk);
        #1;
        st[d] = 1'b1;
        a[d]  = x;
        b[d]  = y;
        ci[d] = c;
        @(posedge clk);
        #1;
        st[d] = 1'b0;
        if (junk) begin
            repeat (2) begin
                a[d]  = 8'($urandom);
                b[d]  = 8'($urandom);
                ci[d] = 1'($urandom);
                st[d] = 1'($urandom);
                @(posedge clk);
                #1;
            end
            st[d] = 1'b0;
        end
        drain();
    endtask

    initial begin
        rst_n = 1'b1;
        st = '0;
        a  = '0;
        b  = '0;
        ci = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (5) @(posedge clk);

        run_op(0, 8'h3C, 8'h42, 1'b0, 1'b0);
        run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0);
        run_op(0, 8'hA5, 8'h5A, 1'b1, 1'b1);

        @(posedge clk);
        #1;
        a[0] = 8'h01;
        b[0] = 8'h02;
        ci[0] = 1'b0;
        st[0] = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        st[0] = 1'b0;
        drain();

        @(posedge clk);
        #1;
        st[0] = 1'b1;
        a[0] = 8'h0F;
        b[0] = 8'h01;
        ci[0] = 1'b0;
        @(posedge clk);
        #1;
        st[0] = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();
        repeat (3) @(posedge clk);
        run_op(0, 8'h10, 8'h20, 1'b0, 1'b0);

        for (int i = 0; i < 512; i++)
            run_op(1, 8'(i & 15), 8'((i >> 4) & 15), 1'(i >> 8), 1'b0);

        for (int i = 0; i < 150; i++)
            run_op(0, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller. Drives one external full-adder cell (a, b, c -> sum, carry) to add two WIDTH-bit operands, one bit per cycle, LSB first.
- Latches the operands on start, feeds each bit pair plus the stored carry to the cell, and collects the sum bits.
- Presents the registered WIDTH-bit result and carry-out with a one-cycle done pulse.
- Sits between a requester (start/operands) and a single shared full-adder instance.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CW, $clog2(WIDTH+1), bit-counter width (derived; do not override).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when the FSM is in IDLE or DONE.
- op_a  input  WIDTH  operand A; captured on an accepted start.
- op_b  input  WIDTH  operand B; captured on an accepted start.
- cin  input  1  carry-in; captured on an accepted start.
- fa_a  output  1  to full-adder input a.
- fa_b  output  1  to full-adder input b.
- fa_c  output  1  to full-adder carry input c.
- fa_sum  input  1  from full-adder sum output.
- fa_carry  input  1  from full-adder carry output.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  registered result; held until the next completion.
- cout  output  1  registered final carry; held with sum.

Behaviour:
- Reset: asynchronous, active-low, as already decided.
  - On rst_n=0, immediately: state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Shift registers, carry register and counter also clear to 0, so fa_a=fa_b=fa_c=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 at edge k -> load a_sh=op_a, b_sh=op_b, carry=cin, cnt=0, r_sh=0; go RUN. Otherwise stay.
  - RUN, each edge:
    - r_sh <= {fa_sum, r_sh[WIDTH-1:1]}.
    - carry <= fa_carry.
    - a_sh and b_sh shift right by 1.
    - cnt <= cnt+1.
    - When cnt==WIDTH-1 at the edge: go DONE, and load sum <= {fa_sum, r_sh[WIDTH-1:1]} and cout <= fa_carry on that same edge.
  - DONE: done=1 for exactly this one cycle.
    - start=1 -> accepted exactly as in IDLE, go RUN.
    - Otherwise go IDLE.
- Full-adder drive:
  - fa_a=a_sh[0], fa_b=b_sh[0], fa_c=carry, combinational from registers, only while in RUN.
  - Forced to 0 in IDLE and DONE.
  - The cell is combinational: fa_sum/fa_carry are sampled in the same cycle they are driven.
- Latency: start accepted at edge k -> RUN occupies cycles k+1..k+WIDTH.
  - sum/cout update at edge k+WIDTH.
  - done high during cycle k+WIDTH (after that edge) until edge k+WIDTH+1.
  - Back-to-back start in DONE: the next done comes WIDTH+1 cycles after the previous one.
- busy=1 exactly during the WIDTH RUN cycles.
- start during RUN is ignored (no queueing); op_a/op_b/cin changes during RUN have no effect.
- sum/cout hold their last value in IDLE and during a subsequent RUN. They change only at completion.
- Arithmetic: {cout, sum} == op_a + op_b + cin (WIDTH+1-bit result; no overflow flag).
- Reset mid-RUN: operation aborted, no done, outputs return to reset values; the next start behaves normally.

Test Plan:
- Reset then idle 5 cycles -> busy=0, done=0, sum=0x00, cout=0, fa_a/fa_b/fa_c=0.
- WIDTH=8, op_a=0x3C, op_b=0x42, cin=0, start pulse -> busy 8 cycles; done 1 cycle at k+8; sum=0x7E, cout=0.
- op_a=0xFF, op_b=0x01, cin=0 -> sum=0x00, cout=1. Also op_a=0xA5, op_b=0x5A, cin=1 -> sum=0x00, cout=1 (carry ripples through all 8 serial steps).
- start held high for 20 cycles with op_a=0x01, op_b=0x02 -> done every 9 cycles, sum=0x03 each time. start pulses during RUN ignored; result unchanged.
- rst_n low at RUN cycle 4 of a 0x0F+0x01 add -> no done, sum=0, cout=0. A new start of 0x10+0x20 -> sum=0x30.
- WIDTH=4 exhaustive: all op_a, op_b, cin (512 cases) against a reference full-adder model -> {cout, sum}==op_a+op_b+cin in every case.
